// File: rtl/lcd_pkg.sv
// Shared types and constants for the FIFO-buffered LCD SPI stream.
package lcd_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StShift} lcd_state_e;

  // Tag bit positions above the data field: word = {rep, ncs, dc, data}
  localparam int unsigned FieldDc  = 0;
  localparam int unsigned FieldNcs = 1;
  localparam int unsigned FieldRep = 2;

  localparam int unsigned Mode8Bits = 8;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with combinational accept/read-ack; never drops data.
module fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SIZE_BITS = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             wreq,
  input  logic [WIDTH-1:0] wdata,
  output logic             wack,
  output logic             full,
  input  logic             rreq,
  output logic [WIDTH-1:0] rdata,
  output logic             rack,
  output logic             empty
);
  localparam int unsigned Depth = 1 << SIZE_BITS;

  logic [WIDTH-1:0]   mem [Depth];
  logic [SIZE_BITS:0] wptr_q, rptr_q;

  // Extra pointer MSB distinguishes full from empty
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[SIZE_BITS] != rptr_q[SIZE_BITS]) &&
                 (wptr_q[SIZE_BITS-1:0] == rptr_q[SIZE_BITS-1:0]);
  assign wack  = wreq & ~full;
  assign rack  = rreq & ~empty;
  assign rdata = mem[rptr_q[SIZE_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wack) wptr_q <= wptr_q + 1'b1;
      if (rack) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wack) mem[wptr_q[SIZE_BITS-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_shift_core.sv
// SPI bit engine: half-period divider, edge counter and CPOL/CPHA shifter.
module spi_shift_core
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned DIV_BITS  = 4,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 mode8,
  input  logic [DIV_BITS-1:0]  div,
  input  logic [DATA_BITS-1:0] data,
  output logic                 run,
  output logic                 last,
  output logic                 sck,
  output logic                 mosi
);
  localparam int unsigned EdgeBits = $clog2(2 * DATA_BITS + 1);

  logic [DATA_BITS-1:0] sreg_q, sreg_d, load_word;
  logic [DIV_BITS-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [EdgeBits-1:0]  edges_q, edges_d;
  logic                 sck_q, sck_d, mosi_q, mosi_d, run_q, run_d;
  logic                 tick, leading, present;

  // 8-bit words are left-aligned so the MSB is always shifted out first
  assign load_word = mode8 ? (data << (DATA_BITS - Mode8Bits)) : data;
  assign tick      = run_q && (cnt_q == '0);
  // Edges count down from 2*W, so an even remaining count marks a leading edge
  assign leading   = ~edges_q[0];
  assign present   = CPHA ? leading : (!leading && edges_q != EdgeBits'(1));

  always_comb begin
    sreg_d  = sreg_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    edges_d = edges_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    run_d   = run_q;
    last    = 1'b0;
    if (start) begin
      run_d   = 1'b1;
      div_d   = div;
      cnt_d   = div;
      sck_d   = CPOL;
      edges_d = mode8 ? EdgeBits'(2 * Mode8Bits) : EdgeBits'(2 * DATA_BITS);
      if (CPHA) begin
        sreg_d = load_word;
      end else begin
        mosi_d = load_word[DATA_BITS-1];
        sreg_d = load_word << 1;
      end
    end else if (tick) begin
      cnt_d   = div_q;
      sck_d   = ~sck_q;
      edges_d = edges_q - 1'b1;
      if (present) begin
        mosi_d = sreg_q[DATA_BITS-1];
        sreg_d = sreg_q << 1;
      end
      if (edges_q == EdgeBits'(1)) begin
        run_d = 1'b0;
        last  = 1'b1;
      end
    end else if (run_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sreg_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      edges_q <= '0;
      sck_q   <= CPOL;
      mosi_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      run_q   <= run_d;
    end
  end

  assign run  = run_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/spi_lcd_stream.sv
// FIFO-buffered LCD SPI master: tagged words {rep, ncs, dc, data} with repeat-fill support.
module spi_lcd_stream
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned FIFO_BITS = 10,
  parameter int unsigned DIV_BITS  = 4,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter int unsigned REP_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [DATA_BITS+2:0] data_in,
  input  logic                 req,
  output logic                 ack,
  input  logic [DIV_BITS-1:0]  div,
  input  logic                 mode8,
  output logic                 fifo_full,
  output logic                 busy,
  output logic                 done,
  output logic                 sck,
  output logic                 mosi,
  output logic                 ncs,
  output logic                 dc
);
  localparam int unsigned WordBits = DATA_BITS + 3;

  lcd_state_e          state_q, state_d;
  logic [WordBits-1:0] word_q, word_d, rdata;
  logic [REP_BITS-1:0] rep_cnt_q, rep_cnt_d;
  logic                hold_q, hold_d, ncs_q, ncs_d, dc_q, dc_d, done_q, done_d;
  logic                rreq, rack, empty, start, run, last, is_rep;

  assign is_rep = word_q[DATA_BITS+FieldRep];

  fifo #(
    .WIDTH    (WordBits),
    .SIZE_BITS(FIFO_BITS)
  ) u_fifo (
    .clk   (clk),
    .nreset(nreset),
    .wreq  (req),
    .wdata (data_in),
    .wack  (ack),
    .full  (fifo_full),
    .rreq  (rreq),
    .rdata (rdata),
    .rack  (rack),
    .empty (empty)
  );

  spi_shift_core #(
    .DATA_BITS(DATA_BITS),
    .DIV_BITS (DIV_BITS),
    .CPOL     (CPOL),
    .CPHA     (CPHA)
  ) u_core (
    .clk   (clk),
    .nreset(nreset),
    .start (start),
    .mode8 (mode8),
    .div   (div),
    .data  (word_q[DATA_BITS-1:0]),
    .run   (run),
    .last  (last),
    .sck   (sck),
    .mosi  (mosi)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    rep_cnt_d = rep_cnt_q;
    hold_d    = hold_q;
    ncs_d     = ncs_q;
    dc_d      = dc_q;
    done_d    = 1'b0;
    rreq      = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      StIdle: begin
        done_d = empty;
        if (!empty || hold_q) state_d = StFetch;
      end
      StFetch: begin
        // A held repeat word is replayed without touching the FIFO
        if (hold_q) begin
          state_d = StLoad;
        end else begin
          rreq = 1'b1;
          if (rack) begin
            word_d  = rdata;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLoad: begin
        if (is_rep) begin
          rep_cnt_d = word_q[REP_BITS-1:0];
          state_d   = StFetch;
        end else begin
          ncs_d   = word_q[DATA_BITS+FieldNcs];
          dc_d    = word_q[DATA_BITS+FieldDc];
          start   = 1'b1;
          state_d = StShift;
          if (rep_cnt_q > REP_BITS'(1)) begin
            hold_d    = 1'b1;
            rep_cnt_d = rep_cnt_q - 1'b1;
          end else begin
            hold_d    = 1'b0;
            rep_cnt_d = '0;
          end
        end
      end
      StShift: begin
        if (last) state_d = (!empty || hold_q) ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= StIdle;
      word_q    <= '0;
      rep_cnt_q <= '0;
      hold_q    <= 1'b0;
      ncs_q     <= 1'b1;
      dc_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      rep_cnt_q <= rep_cnt_d;
      hold_q    <= hold_d;
      ncs_q     <= ncs_d;
      dc_q      <= dc_d;
      done_q    <= done_d;
    end
  end

  assign busy = run || hold_q || (state_q == StLoad && !is_rep);
  assign done = done_q;
  assign ncs  = ncs_q;
  assign dc   = dc_q;

endmodule
